pipe_stall_ctrl: RTL and testbench

Stall controller for the five-stage pipeline. Each cycle it decides whether the instruction in D must be held. When it asserts `stall`, the PC and D register freeze and the E register loads a bubble (PC 0x3000, all other fields 0). It compares D-stage operand use times (Tuse) against the result-ready times (Tnew) of E and M. It also owns the multiply/divide busy counter that blocks HI/LO instructions while the MD unit is running.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_stall_ctrl_if.sv | 32 +++
 rtl/md_busy_counter.sv | 32 +++
 rtl/pipe_stall_ctrl.sv | 71 +++++++
 tb/tb_pipe_stall_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: Tuse/Tnew encoding, MD unit latencies, bubble PC.
// Also hosts the single-producer hazard predicate used by the stall logic.
package pipe_pkg;

  localparam int TNEW_W = 2;
  localparam int REG_W  = 5;

  typedef logic [TNEW_W-1:0] tval_t;
  typedef logic [REG_W-1:0]  reg_t;

  // Tuse of 3 marks an operand the D instruction never reads
  localparam tval_t TUSE_NONE = 2'd3;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  localparam logic [31:0] BUBBLE_PC = 32'h0000_3000;

  function automatic logic src_hazard(input reg_t src, input tval_t tuse,
                                      input reg_t a3, input tval_t tnew);
    return (src != '0) && (src == a3) && (tnew > tuse);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// D/E/M hazard inputs and stall outputs of the stall controller.
// master drives the pipeline-side fields; slave is the controller.
interface pipe_stall_ctrl_if;
  import pipe_pkg::*;

  reg_t  D_rs;
  reg_t  D_rt;
  tval_t D_Tuse_rs;
  tval_t D_Tuse_rt;
  logic  D_is_md;
  reg_t  E_A3;
  tval_t E_Tnew;
  reg_t  M_A3;
  tval_t M_Tnew;
  logic  E_md_start;
  logic  E_md_is_div;
  logic  stall;
  logic  md_busy;

  modport master (
    output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_is_md,
    output E_A3, E_Tnew, M_A3, M_Tnew, E_md_start, E_md_is_div,
    input  stall, md_busy
  );

  modport slave (
    input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_is_md,
    input  E_A3, E_Tnew, M_A3, M_Tnew, E_md_start, E_md_is_div,
    output stall, md_busy
  );

endinterface

// File: rtl/md_busy_counter.sv
// Multiply/divide busy window: loads on start, counts down, saturates at 0.
// md_busy is combinational: high on the start cycle plus the loaded count.
module md_busy_counter #(
  parameter int MULT_CYCLES = pipe_pkg::MULT_CYCLES,
  parameter int DIV_CYCLES  = pipe_pkg::DIV_CYCLES,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  output logic [CNT_W-1:0] cnt,
  output logic             md_busy
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

  // A start while already busy reloads: the newest operation owns the unit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= is_div ? DIV_LD : MULT_LD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign md_busy = start || (cnt != '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: Tuse/Tnew hazard check on D vs E/M plus MD busy stall.
// Optional perf counters under PIPE_STALL_PERF_EN.
module pipe_stall_ctrl #(
  parameter int MULT_CYCLES = pipe_pkg::MULT_CYCLES,
  parameter int DIV_CYCLES  = pipe_pkg::DIV_CYCLES,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  pipe_stall_ctrl_if.slave  bus
`ifdef PIPE_STALL_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       md_stall_cycles
`endif
);
  import pipe_pkg::*;

  localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;

  if ((1 << CNT_W) <= MD_MAX) begin : g_cnt_too_narrow
    $error("CNT_W too small for MULT_CYCLES/DIV_CYCLES");
  end

  logic [CNT_W-1:0] md_cnt;
  logic             md_busy_int;
  logic             stall_rs;
  logic             stall_rt;
  logic             stall_md;
  logic             stall_int;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_cnt (
    .clk     (clk),
    .reset   (reset),
    .start   (bus.E_md_start),
    .is_div  (bus.E_md_is_div),
    .cnt     (md_cnt),
    .md_busy (md_busy_int)
  );

  // Tnew never exceeds 2, so an unused operand (Tuse 3) cannot stall
  assign stall_rs = src_hazard(bus.D_rs, bus.D_Tuse_rs, bus.E_A3, bus.E_Tnew) ||
                    src_hazard(bus.D_rs, bus.D_Tuse_rs, bus.M_A3, bus.M_Tnew);
  assign stall_rt = src_hazard(bus.D_rt, bus.D_Tuse_rt, bus.E_A3, bus.E_Tnew) ||
                    src_hazard(bus.D_rt, bus.D_Tuse_rt, bus.M_A3, bus.M_Tnew);
  assign stall_md = bus.D_is_md && md_busy_int;

  assign stall_int   = stall_rs || stall_rt || stall_md;
  assign bus.stall   = stall_int;
  assign bus.md_busy = md_busy_int;

  a_cnt_range : assert property (@(posedge clk) disable iff (!reset)
                                 int'(md_cnt) <= MD_MAX);

`ifdef PIPE_STALL_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles    <= '0;
      md_stall_cycles <= '0;
    end else begin
      if (stall_int) stall_cycles    <= stall_cycles + 32'd1;
      if (stall_md)  md_stall_cycles <= md_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: vector table, MD window / reset sequences, random vs model.
// Perf counter checks are compiled in with PIPE_STALL_PERF_EN.
module tb_pipe_stall_ctrl;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl_if bus();

`ifdef PIPE_STALL_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] md_stall_cycles;
`endif

  pipe_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef PIPE_STALL_PERF_EN
    ,
    .stall_cycles    (stall_cycles),
    .md_stall_cycles (md_stall_cycles)
`endif
  );

  typedef struct {
    logic [4:0] rs, rt;
    logic [1:0] tu_rs, tu_rt;
    logic [4:0] ea3;
    logic [1:0] etn;
    logic [4:0] ma3;
    logic [1:0] mtn;
    logic       exp_stall;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] tur, input logic [1:0] tut, input logic is_md,
                       input logic [4:0] ea3, input logic [1:0] etn,
                       input logic [4:0] ma3, input logic [1:0] mtn,
                       input logic start, input logic is_div);
    bus.D_rs = rs; bus.D_rt = rt; bus.D_Tuse_rs = tur; bus.D_Tuse_rt = tut;
    bus.D_is_md = is_md; bus.E_A3 = ea3; bus.E_Tnew = etn;
    bus.M_A3 = ma3; bus.M_Tnew = mtn; bus.E_md_start = start; bus.E_md_is_div = is_div;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: the operand is ready when the latest matching producer finishes
  function automatic int ready_time(input logic [4:0] src, input logic [4:0] ea3, input int etn,
                                    input logic [4:0] ma3, input int mtn);
    int t = 0;
    if (src == 0) return 0;
    if (src == ea3 && etn > t) t = etn;
    if (src == ma3 && mtn > t) t = mtn;
    return t;
  endfunction

  task automatic md_window(input logic is_div, input int n, input string tag);
    drive(0, 0, 3, 3, 1, 0, 0, 0, 0, 1, is_div);
    #3;
    chk({tag, "_busy_start"}, bus.md_busy, 1);
    chk({tag, "_stall_start"}, bus.stall, 1);
    step();
    bus.E_md_start = 1'b0;
    for (int i = 1; i <= n; i++) begin
      #3;
      chk({tag, "_busy_win"}, bus.md_busy, 1);
      if (i == n) chk({tag, "_stall_last"}, bus.stall, 1);
      step();
    end
    #3;
    chk({tag, "_busy_end"}, bus.md_busy, 0);
    chk({tag, "_stall_end"}, bus.stall, 0);
  endtask

  initial begin
    int busy_until;
    int cyc;

    vt[0] = '{8,  0, 0, 3,  8, 2,  0, 0, 1'b1};
    vt[1] = '{8,  0, 0, 3,  8, 0,  0, 0, 1'b0};
    vt[2] = '{0,  0, 0, 0,  0, 2,  0, 0, 1'b0};
    vt[3] = '{5,  0, 0, 3,  0, 0,  5, 1, 1'b1};
    vt[4] = '{5,  0, 1, 3,  0, 0,  5, 1, 1'b0};
    vt[5] = '{3,  9, 0, 1,  9, 2,  0, 0, 1'b1};
    vt[6] = '{3,  9, 0, 3,  9, 2,  0, 0, 1'b0};
    vt[7] = '{7,  0, 1, 3,  7, 1,  0, 0, 1'b0};
    vt[8] = '{4,  0, 0, 3,  2, 2,  4, 0, 1'b0};
    vt[9] = '{31, 31, 3, 0, 0, 0, 31, 2, 1'b1};

    // Reset state: md_busy follows start, counter stays cleared
    drive(0, 0, 3, 3, 1, 0, 0, 0, 0, 1, 0);
    #3;
    chk("rst_busy_follows_start", bus.md_busy, 1);
    step();
    bus.E_md_start = 1'b0;
    #1;
    chk("rst_busy_idle", bus.md_busy, 0);
    chk("rst_stall_idle", bus.stall, 0);
`ifdef PIPE_STALL_PERF_EN
    chk("rst_perf_stall", stall_cycles, 0);
    chk("rst_perf_md", md_stall_cycles, 0);
`endif
    #1 reset = 1'b1;
    step();

    md_window(1'b0, 5, "mult");
`ifdef PIPE_STALL_PERF_EN
    chk("perf_stall_cycles", stall_cycles, 6);
    chk("perf_md_stall_cycles", md_stall_cycles, 6);
`endif
    step();
    md_window(1'b1, 10, "div");
    step();

    foreach (vt[i]) begin
      drive(vt[i].rs, vt[i].rt, vt[i].tu_rs, vt[i].tu_rt, 1'b0,
            vt[i].ea3, vt[i].etn, vt[i].ma3, vt[i].mtn, 1'b0, 1'b0);
      #3;
      chk($sformatf("vec%0d_stall", i), bus.stall, vt[i].exp_stall);
      step();
    end

    // Reset pulled mid-div, between clock edges
    drive(0, 0, 3, 3, 1, 0, 0, 0, 0, 1, 1);
    step();
    bus.E_md_start = 1'b0;
    step(); step(); step();
    #1;
    chk("middiv_busy_before", bus.md_busy, 1);
    #1 reset = 1'b0;
    #1;
    chk("middiv_busy_async", bus.md_busy, 0);
    chk("middiv_stall_async", bus.stall, 0);
    step();
    #2 reset = 1'b1;
    step();
    chk("middiv_busy_after", bus.md_busy, 0);
    step();
    chk("middiv_busy_after2", bus.md_busy, 0);

    // Random stimulus against the cycle-indexed busy-window model
    busy_until = -1;
    cyc = 0;
    for (int k = 0; k < 400; k++) begin
      logic [4:0] rs, rt, ea3, ma3;
      logic [1:0] tur, tut, etn, mtn;
      logic       is_md, start, is_div;
      bit         exp_busy, exp_stall;
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
      ea3 = 5'($urandom_range(0, 3)); ma3 = 5'($urandom_range(0, 3));
      tur = 2'($urandom_range(0, 3)); tut = 2'($urandom_range(0, 3));
      etn = 2'($urandom_range(0, 2)); mtn = 2'($urandom_range(0, 2));
      is_md = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 9) == 0);
      is_div = 1'($urandom_range(0, 1));
      drive(rs, rt, tur, tut, is_md, ea3, etn, ma3, mtn, start, is_div);
      exp_busy = start || (cyc <= busy_until);
      if (start) busy_until = cyc + (is_div ? 10 : 5);
      exp_stall = (ready_time(rs, ea3, etn, ma3, mtn) > int'(tur)) ||
                  (ready_time(rt, ea3, etn, ma3, mtn) > int'(tut)) ||
                  (is_md && exp_busy);
      #3;
      chk("rand_busy", bus.md_busy, exp_busy);
      chk("rand_stall", bus.stall, exp_stall);
      step();
      cyc++;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
